id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/pcpu_pkg.sv | 23 ++
 rtl/id_ex_stage_hazard_fwd_unit.sv | 52 +++++
 rtl/id_ex_stage.sv | 83 ++++++++
 tb/tb_id_ex_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_pkg.sv
// pcpu_pkg: shared widths, control-bit indices and forward-select encoding for the pipeline
package pcpu_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam int CTRL_W = 16;
  localparam int CNT_W = 16;
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ = 1;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_EX = 2'd1, FWD_MEM = 2'd2} fwd_sel_e;
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]  wt;
  } ex_bundle_t;
  // A producer feeds a source only when it writes, the source is used and is not r0.
  function automatic logic src_hit(logic live, logic [REG_W-1:0] dst, logic [REG_W-1:0] src,
                                   logic uses);
    return live && uses && (src != '0) && (dst == src);
  endfunction
endpackage

// File: rtl/id_ex_stage_hazard_fwd_unit.sv
// hazard_fwd_unit: operand match, forward selection and stall generation for the ID/EX stage
// Ports: decode sources/uses/rdata in; EX producer (live, load, dst, result) and MEM producer
//        (live, dst, result) in; op_a_o/op_b_o selected operands and stall_o out.
// Config: ID_EX_FWD_EN enables forwarding; otherwise any EX/MEM dependency stalls.
module hazard_fwd_unit
  import pcpu_pkg::*;
(
  input  logic              id_valid_i,
  input  logic              flush_i,
  input  logic [REG_W-1:0]  rs_i,
  input  logic [REG_W-1:0]  rt_i,
  input  logic              uses_rs_i,
  input  logic              uses_rt_i,
  input  logic [DATA_W-1:0] rdata_a_i,
  input  logic [DATA_W-1:0] rdata_b_i,
  input  logic              ex_live_i,
  input  logic              ex_load_i,
  input  logic [REG_W-1:0]  ex_wt_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic              mem_live_i,
  input  logic [REG_W-1:0]  mem_wt_i,
  input  logic [DATA_W-1:0] mem_result_i,
  output logic [DATA_W-1:0] op_a_o,
  output logic [DATA_W-1:0] op_b_o,
  output logic              stall_o
);
  logic ex_a, ex_b, mem_a, mem_b;
  assign ex_a = src_hit(ex_live_i, ex_wt_i, rs_i, uses_rs_i);
  assign ex_b = src_hit(ex_live_i, ex_wt_i, rt_i, uses_rt_i);
  assign mem_a = src_hit(mem_live_i, mem_wt_i, rs_i, uses_rs_i);
  assign mem_b = src_hit(mem_live_i, mem_wt_i, rt_i, uses_rt_i);
`ifdef ID_EX_FWD_EN
  fwd_sel_e sel_a, sel_b;
  always_comb begin
    sel_a = ex_a ? FWD_EX : mem_a ? FWD_MEM : FWD_RF;
    sel_b = ex_b ? FWD_EX : mem_b ? FWD_MEM : FWD_RF;
    op_a_o = (rs_i == '0) ? '0 : (sel_a == FWD_EX) ? ex_result_i :
             (sel_a == FWD_MEM) ? mem_result_i : rdata_a_i;
    op_b_o = (rt_i == '0) ? '0 : (sel_b == FWD_EX) ? ex_result_i :
             (sel_b == FWD_MEM) ? mem_result_i : rdata_b_i;
    // Only a load in EX cannot be forwarded in time; one bubble moves it to MEM.
    stall_o = id_valid_i & ~flush_i & ex_load_i & (ex_a | ex_b);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_result_i, mem_result_i, ex_load_i};
  assign op_a_o = rdata_a_i;
  assign op_b_o = rdata_b_i;
  // Without forwarding the consumer waits until the producer has reached WB.
  assign stall_o = id_valid_i & ~flush_i & (ex_a | ex_b | mem_a | mem_b);
`endif
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, hazard stall and stall counter
// Ports: clk, rst (async, active-high); id_* decode bundle; ex_result and mem_* producers;
//        flush kills decode; stall_out holds PC and IF/ID; ex_* registered EX bundle;
//        stall_cnt saturating count of stall cycles.
// Config: ID_EX_FWD_EN enables EX/MEM forwarding with load-use stall only.
module id_ex_stage
  import pcpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs_addr,
  input  logic [REG_W-1:0]  id_rt_addr,
  input  logic [REG_W-1:0]  id_wt_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rdata_A,
  input  logic [DATA_W-1:0] id_rdata_B,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_reg_write,
  input  logic [REG_W-1:0]  mem_wt_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              flush,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_W-1:0]  ex_wt_addr,
  output logic [CNT_W-1:0]  stall_cnt
);
  ex_bundle_t ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [DATA_W-1:0] op_a, op_b;
  logic stall_raw, take;
  hazard_fwd_unit u_hfu (
    .id_valid_i  (id_valid),
    .flush_i     (flush),
    .rs_i        (id_rs_addr),
    .rt_i        (id_rt_addr),
    .uses_rs_i   (id_uses_rs),
    .uses_rt_i   (id_uses_rt),
    .rdata_a_i   (id_rdata_A),
    .rdata_b_i   (id_rdata_B),
    .ex_live_i   (ex_q.valid & ex_q.ctrl[CTRL_REG_WRITE]),
    .ex_load_i   (ex_q.valid & ex_q.ctrl[CTRL_MEM_READ]),
    .ex_wt_i     (ex_q.wt),
    .ex_result_i (ex_result),
    .mem_live_i  (mem_reg_write),
    .mem_wt_i    (mem_wt_addr),
    .mem_result_i(mem_result),
    .op_a_o      (op_a),
    .op_b_o      (op_b),
    .stall_o     (stall_raw)
  );
  // A MEM producer may still be presented during reset; reset must silence the stall.
  assign stall_out = stall_raw & ~rst;
  always_comb begin
    take = id_valid & ~flush & ~stall_out;
    ex_d = take ? ex_bundle_t'{valid: 1'b1, op_a: op_a, op_b: op_b, imm: id_imm,
                               ctrl: id_ctrl, wt: id_wt_addr} : ex_bundle_t'('0);
    stall_cnt_d = (stall_out && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign ex_valid = ex_q.valid;
  assign ex_op_a = ex_q.op_a;
  assign ex_op_b = ex_q.op_b;
  assign ex_imm = ex_q.imm;
  assign ex_ctrl = ex_q.ctrl;
  assign ex_wt_addr = ex_q.wt;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table, directed and random checks of id_ex_stage against a reference model
module tb_id_ex_stage;
  logic clk = 1'b0, rst;
  logic id_valid, id_uses_rs, id_uses_rt, mem_reg_write, flush;
  logic [4:0] id_rs_addr, id_rt_addr, id_wt_addr, mem_wt_addr;
  logic [31:0] id_rdata_A, id_rdata_B, id_imm, ex_result, mem_result;
  logic [15:0] id_ctrl;
  logic stall_out, ex_valid;
  logic [31:0] ex_op_a, ex_op_b, ex_imm;
  logic [15:0] ex_ctrl, stall_cnt;
  logic [4:0] ex_wt_addr;
  int n_vec = 0, n_bad = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_wt_addr(id_wt_addr), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_rdata_A(id_rdata_A), .id_rdata_B(id_rdata_B),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .ex_result(ex_result),
    .mem_reg_write(mem_reg_write), .mem_wt_addr(mem_wt_addr), .mem_result(mem_result),
    .flush(flush), .stall_out(stall_out), .ex_valid(ex_valid), .ex_op_a(ex_op_a),
    .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_wt_addr(ex_wt_addr),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction the EX stage should hold, plus the stall count.
  logic m_valid;
  logic [31:0] m_a, m_b, m_imm;
  logic [15:0] m_ctrl, m_cnt;
  logic [4:0] m_wt;

  typedef struct {
    logic [4:0] dst;
    logic [31:0] data;
  } prod_t;

  // Live writers visible to decode, youngest first.
  function automatic void producers(output prod_t q[$]);
    q = {};
    if (m_valid && m_ctrl[0]) q.push_back('{dst: m_wt, data: ex_result});
    if (mem_reg_write) q.push_back('{dst: mem_wt_addr, data: mem_result});
  endfunction

  function automatic logic depends(logic [4:0] src, logic uses, logic [4:0] dst);
    return uses && src != 0 && src == dst;
  endfunction

  function automatic logic [31:0] pick(logic [4:0] src, logic uses, logic [31:0] rdata);
`ifdef ID_EX_FWD_EN
    prod_t q[$];
    producers(q);
    if (src == 0) return 32'h0;
    foreach (q[i]) if (depends(src, uses, q[i].dst)) return q[i].data;
`endif
    return rdata;
  endfunction

  function automatic logic model_stall();
    prod_t q[$];
    logic need = 1'b0;
    producers(q);
    foreach (q[i]) begin
      logic hit = depends(id_rs_addr, id_uses_rs, q[i].dst) ||
                  depends(id_rt_addr, id_uses_rt, q[i].dst);
`ifdef ID_EX_FWD_EN
      // only the EX-stage entry (index 0 when present) can be a load
      if (hit && i == 0 && m_valid && m_ctrl[0] && m_ctrl[1]) need = 1'b1;
`else
      if (hit) need = 1'b1;
`endif
    end
    return !rst && id_valid && !flush && need;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic s, take;
    @(posedge clk);
    s = model_stall();
    take = id_valid && !flush && !s;
    m_a = take ? pick(id_rs_addr, id_uses_rs, id_rdata_A) : 32'h0;
    m_b = take ? pick(id_rt_addr, id_uses_rt, id_rdata_B) : 32'h0;
    m_valid = take;
    m_imm = take ? id_imm : 32'h0;
    m_ctrl = take ? id_ctrl : 16'h0;
    m_wt = take ? id_wt_addr : 5'h0;
    if (s && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
    #1;
  endtask

  task automatic check_model();
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_op_a", ex_op_a, m_a);
    chk("ex_op_b", ex_op_b, m_b);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
    chk("ex_wt_addr", 32'(ex_wt_addr), 32'(m_wt));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    {m_valid, m_a, m_b, m_imm, m_ctrl, m_wt, m_cnt} = '0;
    chk("rst_stall_out", 32'(stall_out), 32'h0);
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_ex_op_a", ex_op_a, 32'h0);
    chk("rst_ex_op_b", ex_op_b, 32'h0);
    chk("rst_ex_imm", ex_imm, 32'h0);
    chk("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("rst_ex_wt", 32'(ex_wt_addr), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    rst = 1'b0;
    #1;
  endtask

  task automatic idle();
    {id_valid, id_uses_rs, id_uses_rt, mem_reg_write, flush} = '0;
    {id_rs_addr, id_rt_addr, id_wt_addr, mem_wt_addr} = '0;
    {id_rdata_A, id_rdata_B, id_imm, ex_result, mem_result} = '0;
    id_ctrl = '0;
  endtask

  task automatic dec(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wt,
                     input logic ur, input logic ut, input logic [31:0] a,
                     input logic [31:0] b, input logic [15:0] ctrl);
    id_valid = 1'b1;
    flush = 1'b0;
    {id_rs_addr, id_rt_addr, id_wt_addr, id_uses_rs, id_uses_rt} = {rs, rt, wt, ur, ut};
    {id_rdata_A, id_rdata_B, id_ctrl} = {a, b, ctrl};
    id_imm = a ^ b;
  endtask

  typedef struct {
    logic v;
    logic [4:0] rs, rt, wt;
    logic ur, ut;
    logic [31:0] a, b, imm;
    logic [15:0] ctrl;
    logic fl;
    logic e_st, e_v;
    logic [31:0] e_a, e_b, e_imm;
    logic [15:0] e_ctrl;
    logic [4:0] e_wt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // No entry writes a register, so both build variants expect the same results.
    tbl[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h11, 32'h22, 32'h33, 16'h0004, 1'b0,
               1'b0, 1'b1, 32'h11, 32'h22, 32'h33, 16'h0004, 5'd3};
    tbl[1] = '{1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h44, 32'h55, 32'h66, 16'h0004, 1'b0,
               1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0, 5'd0};
    tbl[2] = '{1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h44, 32'h55, 32'h66, 16'h0004, 1'b1,
               1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0, 5'd0};
    tbl[3] = '{1'b1, 5'd9, 5'd10, 5'd31, 1'b0, 1'b0, 32'hAAAA5555, 32'h5555AAAA, 32'hFFFFFFFF,
               16'hFFF0, 1'b0, 1'b0, 1'b1, 32'hAAAA5555, 32'h5555AAAA, 32'hFFFFFFFF, 16'hFFF0,
               5'd31};
    tbl[4] = '{1'b1, 5'd4, 5'd6, 5'd5, 1'b0, 1'b0, 32'h1, 32'h2, 32'h3, 16'h0002, 1'b0,
               1'b0, 1'b1, 32'h1, 32'h2, 32'h3, 16'h0002, 5'd5};
    tbl[5] = '{1'b1, 5'd5, 5'd5, 5'd8, 1'b1, 1'b1, 32'h77, 32'h88, 32'h0, 16'h8000, 1'b0,
               1'b0, 1'b1, 32'h77, 32'h88, 32'h0, 16'h8000, 5'd8};

    idle();
    do_reset();
    foreach (tbl[i]) begin
      id_valid = tbl[i].v;
      {id_rs_addr, id_rt_addr, id_wt_addr} = {tbl[i].rs, tbl[i].rt, tbl[i].wt};
      {id_uses_rs, id_uses_rt, flush} = {tbl[i].ur, tbl[i].ut, tbl[i].fl};
      {id_rdata_A, id_rdata_B, id_imm, id_ctrl} = {tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].ctrl};
      #1;
      chk($sformatf("tbl%0d_stall", i), 32'(stall_out), 32'(tbl[i].e_st));
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(ex_valid), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d_op_a", i), ex_op_a, tbl[i].e_a);
      chk($sformatf("tbl%0d_op_b", i), ex_op_b, tbl[i].e_b);
      chk($sformatf("tbl%0d_imm", i), ex_imm, tbl[i].e_imm);
      chk($sformatf("tbl%0d_ctrl", i), 32'(ex_ctrl), 32'(tbl[i].e_ctrl));
      chk($sformatf("tbl%0d_wt", i), 32'(ex_wt_addr), 32'(tbl[i].e_wt));
    end

    // Mid-stream reset pulse between clock edges, with a live EX instruction.
    dec(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'h1234, 32'h5678, 16'h0005);
    tick();
    chk("pre_rst_valid", 32'(ex_valid), 32'h1);
    idle();
    do_reset();

`ifdef ID_EX_FWD_EN
    // EX forwarding of a fresh add result over a stale register-file value.
    dec(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0001);
    tick();
    ex_result = 32'h10;
    dec(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 32'h0, 32'h0, 16'h0001);
    #1;
    chk("fwd_ex_stall", 32'(stall_out), 32'h0);
    tick();
    chk("fwd_ex_op_a", ex_op_a, 32'h10);
    // Load-use: one stall with a bubble, then MEM forwarding.
    idle();
    dec(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0003);
    tick();
    dec(5'd0, 5'd5, 5'd6, 1'b0, 1'b1, 32'h0, 32'h0, 16'h0001);
    #1;
    chk("lu_stall", 32'(stall_out), 32'h1);
    tick();
    chk("lu_bubble", 32'(ex_valid), 32'h0);
    chk("lu_bubble_b", ex_op_b, 32'h0);
    chk("lu_cnt", 32'(stall_cnt), 32'h1);
    {mem_reg_write, mem_wt_addr, mem_result} = {1'b1, 5'd5, 32'hDEADBEEF};
    #1;
    chk("lu_stall_end", 32'(stall_out), 32'h0);
    tick();
    chk("lu_op_b", ex_op_b, 32'hDEADBEEF);
    chk("lu_valid", 32'(ex_valid), 32'h1);
    chk("lu_cnt_hold", 32'(stall_cnt), 32'h1);
    // EX producer beats MEM producer for r7; then a MEM-only match.
    idle();
    dec(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0001);
    tick();
    {ex_result, mem_reg_write, mem_wt_addr, mem_result} = {32'h1, 1'b1, 5'd7, 32'h2};
    dec(5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 32'h55, 32'h0, 16'h0000);
    tick();
    chk("prio_op_a", ex_op_a, 32'h1);
    dec(5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 32'h55, 32'h0, 16'h0000);
    tick();
    chk("mem_op_a", ex_op_a, 32'h2);
    // Writers to r0 never forward; r0 reads as 0.
    dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0001);
    tick();
    {ex_result, mem_reg_write, mem_wt_addr, mem_result} = {32'h5, 1'b1, 5'd0, 32'h6};
    dec(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 32'h99, 32'h0, 16'h0000);
    tick();
    chk("r0_op_a", ex_op_a, 32'h0);
`else
    // Back-to-back dependent adds on r2: two stall cycles, then register-file value.
    dec(5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0001);
    tick();
    dec(5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 32'h0, 32'h0, 16'h0001);
    #1;
    chk("nf_stall1", 32'(stall_out), 32'h1);
    tick();
    chk("nf_bubble1", 32'(ex_valid), 32'h0);
    {mem_reg_write, mem_wt_addr, mem_result} = {1'b1, 5'd2, 32'hABCD};
    #1;
    chk("nf_stall2", 32'(stall_out), 32'h1);
    tick();
    chk("nf_bubble2", 32'(ex_valid), 32'h0);
    mem_reg_write = 1'b0;
    id_rdata_A = 32'h1234;
    #1;
    chk("nf_stall3", 32'(stall_out), 32'h0);
    tick();
    chk("nf_op_a", ex_op_a, 32'h1234);
    chk("nf_cnt", 32'(stall_cnt), 32'h2);
    // Held MEM dependency stalls continuously; the counter must saturate.
    idle();
    do_reset();
    {mem_reg_write, mem_wt_addr} = {1'b1, 5'd4};
    dec(5'd4, 5'd0, 5'd1, 1'b1, 1'b0, 32'h0, 32'h0, 16'h0001);
    repeat (70000) tick();
    chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    chk("sat_stall", 32'(stall_out), 32'h1);
    idle();
`endif

    // Flush during a load-use dependency wins over the stall.
    idle();
    dec(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0003);
    tick();
    dec(5'd0, 5'd5, 5'd6, 1'b0, 1'b1, 32'h0, 32'h0, 16'h0001);
    #1;
    chk("fl_stall_pre", 32'(stall_out), 32'h1);
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall_out), 32'h0);
    tick();
    chk("fl_valid", 32'(ex_valid), 32'h0);
    chk("fl_cnt", 32'(stall_cnt), 32'(m_cnt));
    check_model();

    // Random traffic against the model, with occasional mid-cycle resets.
    idle();
    for (int n = 0; n < 4000; n++) begin
      id_valid = $urandom_range(0, 9) != 0;
      flush = $urandom_range(0, 15) == 0;
      id_rs_addr = 5'($urandom_range(0, 3));
      id_rt_addr = 5'($urandom_range(0, 3));
      id_wt_addr = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom);
      id_uses_rt = 1'($urandom);
      id_rdata_A = $urandom;
      id_rdata_B = $urandom;
      id_imm = $urandom;
      id_ctrl = 16'($urandom);
      ex_result = $urandom;
      mem_reg_write = $urandom_range(0, 2) == 0;
      mem_wt_addr = 5'($urandom_range(0, 3));
      mem_result = $urandom;
      #1;
      chk("rnd_stall", 32'(stall_out), 32'(model_stall()));
      tick();
      check_model();
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
